// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, replays them one at a time to an
// external combinational ALU, and returns each result as a registered response.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_a, cmd_b operands, cmd_sel opcode
//   alu_a, alu_b, alu_sel registered operands/opcode driven to the ALU
//   alu_result            combinational ALU result
//   rsp_valid/rsp_ready   response handshake
//   rsp_result, rsp_sel   captured result and the opcode that produced it
//   rsp_zero, rsp_neg     result == 0, result[3]
//   op_count              completed-response counter (wraps)
module alu_cmd_sequencer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic [1:0] cmd_sel,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [1:0] alu_sel,
   input  logic [3:0] alu_result,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [3:0] rsp_result,
   output logic [1:0] rsp_sel,
   output logic       rsp_zero,
   output logic       rsp_neg,
   output logic [7:0] op_count
);

   localparam int unsigned DW = 4;
   localparam int unsigned SW = 2;
   localparam int unsigned EW = 2 * DW + SW;
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   // Command FIFO storage and bookkeeping
   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          push_c, pop_c, empty_c;
   logic [DW-1:0] head_a_c, head_b_c;
   logic [SW-1:0] head_sel_c;

   // Sequencer state
   state_e        state_q, state_d;
   logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [SW-1:0] alu_sel_q, alu_sel_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_result_q, rsp_result_d;
   logic [SW-1:0] rsp_sel_q, rsp_sel_d;
   logic          rsp_zero_q, rsp_zero_d;
   logic          rsp_neg_q, rsp_neg_d;
   logic [7:0]    op_count_q, op_count_d;

   // Ready depends on the registered fill count only, so it reads 1 in reset
   assign cmd_ready = (count_q != CW'(DEPTH));
   assign empty_c   = (count_q == '0);
   assign push_c    = cmd_valid && cmd_ready;
   assign {head_a_c, head_b_c, head_sel_c} = mem_q[rd_ptr_q];
   assign count_d   = count_q + CW'(push_c) - CW'(pop_c);

   // FIFO payload; contents are don't-care while the count says empty
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_sel};
      end
   end

   // FIFO pointers and fill count; power-of-2 depth lets pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_sel_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_sel_q    <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_neg_q    <= 1'b0;
         op_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_sel_q    <= alu_sel_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_sel_q    <= rsp_sel_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_neg_q    <= rsp_neg_d;
         op_count_q   <= op_count_d;
      end
   end

   // Next-state: load head -> drive ALU one cycle -> hold response until taken
   always_comb begin
      state_d      = state_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_sel_d    = alu_sel_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_sel_d    = rsp_sel_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_neg_d    = rsp_neg_q;
      op_count_d   = op_count_q;
      pop_c        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty_c) begin
               alu_a_d   = head_a_c;
               alu_b_d   = head_b_c;
               alu_sel_d = head_sel_c;
               pop_c     = 1'b1;
               state_d   = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            rsp_result_d = alu_result;
            rsp_sel_d    = alu_sel_q;
            rsp_zero_d   = (alu_result == '0);
            rsp_neg_d    = alu_result[DW-1];
            rsp_valid_d  = 1'b1;
            state_d      = ST_HOLD;
         end
         ST_HOLD: begin
            // rsp_valid is always high here, so rsp_ready alone completes the handshake
            if (rsp_ready) begin
               op_count_d  = op_count_q + 8'd1;
               rsp_valid_d = 1'b0;
               if (!empty_c) begin
                  alu_a_d   = head_a_c;
                  alu_b_d   = head_b_c;
                  alu_sel_d = head_sel_c;
                  pop_c     = 1'b1;
                  state_d   = ST_DRIVE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_sel    = alu_sel_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_sel    = rsp_sel_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_neg    = rsp_neg_q;
   assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: directed commands, a queue of hand-computed
// expected responses, and a monitor that checks every response handshake.
module tb_alu_cmd_sequencer;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_a, cmd_b;
   logic [1:0] cmd_sel;
   logic [3:0] alu_a, alu_b;
   logic [1:0] alu_sel;
   logic [3:0] alu_result;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_result;
   logic [1:0] rsp_sel;
   logic       rsp_zero, rsp_neg;
   logic [7:0] op_count;

   typedef struct packed {
      logic [3:0] res;
      logic [1:0] sel;
      logic       zero;
      logic       neg;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   hs_n     = 0;
   int   first_hs = 0;
   int   last_hs  = 0;

   alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_sel    (cmd_sel),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_sel    (rsp_sel),
      .rsp_zero   (rsp_zero),
      .rsp_neg    (rsp_neg),
      .op_count   (op_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream combinational ALU
   always_comb begin
      case (alu_sel)
         2'b00:   alu_result = alu_a + alu_b;
         2'b01:   alu_result = alu_a - alu_b;
         2'b10:   alu_result = alu_a & alu_b;
         default: alu_result = alu_a | alu_b;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic rsp_t mk(input logic [3:0] r, input logic [1:0] s);
      rsp_t e;
      e.res  = r;
      e.sel  = s;
      e.zero = (r == 4'd0);
      e.neg  = r[3];
      return e;
   endfunction

   // Monitor: every response handshake must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (hs_n == 0) first_hs = cyc;
         last_hs = cyc;
         hs_n++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp actual=0x%0h required=none", rsp_result);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_tuple", 32'({rsp_result, rsp_sel, rsp_zero, rsp_neg}), 32'(mon_e));
         end
      end
   end

   // Called at #1 after a rising edge; returns at #1 after the accepting edge
   task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                       input logic [3:0] r);
      int n;
      n = 0;
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_sel   = s;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         checks++;
         failures++;
         $display("FAIL push_timeout actual=cmd_ready=0 required=1");
         cmd_valid = 1'b0;
      end else begin
         exp_q.push_back(mk(r, s));
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      #1;
      exp_q.delete();
      check("rst_op_count", 32'(op_count), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b1;
      cmd_a     = 4'd3;
      cmd_b     = 4'd5;
      cmd_sel   = 2'b00;
      rsp_ready = 1'b1;

      // Reset values; command offered during reset must be ignored
      #2;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_op_count", 32'(op_count), 32'd0);
      check("rst_alu_ab", 32'({alu_a, alu_b, alu_sel}), 32'd0);
      check("rst_rsp", 32'({rsp_result, rsp_sel, rsp_zero, rsp_neg}), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      rst_n     = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);

      // Single-command latency: 3+5 add
      cmd_valid = 1'b1;
      cmd_a = 4'd3; cmd_b = 4'd5; cmd_sel = 2'b00;
      exp_q.push_back(mk(4'b1000, 2'b00));
      @(posedge clk); #1;          // E0: pushed
      cmd_valid = 1'b0;
      check("lat_e0_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;          // E1: ALU operands loaded
      check("lat_e1_alu", 32'({alu_a, alu_b, alu_sel}), 32'({4'd3, 4'd5, 2'b00}));
      check("lat_e1_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;          // E2: response valid
      check("lat_e2_rsp_valid", 32'(rsp_valid), 32'd1);
      check("lat_e2_rsp_result", 32'(rsp_result), 32'b1000);
      @(posedge clk); #1;          // E3: handshake done
      check("lat_e3_op_count", 32'(op_count), 32'd1);
      check("lat_e3_rsp_valid", 32'(rsp_valid), 32'd0);
      check("lat_alu_hold", 32'({alu_a, alu_b}), 32'({4'd3, 4'd5}));

      // All four opcodes on 3,5 back to back; one response per 2 cycles
      do_reset();
      rsp_ready = 1'b1;
      hs_n = 0;
      push(4'd3, 4'd5, 2'b00, 4'b1000);
      push(4'd3, 4'd5, 2'b01, 4'b1110);
      push(4'd3, 4'd5, 2'b10, 4'b0001);
      push(4'd3, 4'd5, 2'b11, 4'b0111);
      drain();
      check("ops_op_count", 32'(op_count), 32'd4);
      check("ops_hs_count", 32'(hs_n), 32'd4);
      check("ops_throughput", 32'(last_hs - first_hs), 32'd6);

      // Zero result from subtraction
      push(4'd5, 4'd5, 2'b01, 4'b0000);
      drain();

      // Back-pressure: fill to DEPTH with one in HOLD, extra push ignored
      do_reset();
      rsp_ready = 1'b0;
      push(4'd1,  4'd2,  2'b00, 4'd3);
      push(4'd7,  4'd3,  2'b01, 4'd4);
      push(4'd12, 4'd10, 2'b10, 4'd8);
      push(4'd9,  4'd6,  2'b11, 4'd15);
      push(4'd15, 4'd1,  2'b00, 4'd0);
      check("full_cmd_ready", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b1;
      cmd_a = 4'd2; cmd_b = 4'd2; cmd_sel = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("full_still_full", 32'(cmd_ready), 32'd0);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_stable", 32'({rsp_result, rsp_sel}), 32'({4'd3, 2'b00}));
      rsp_ready = 1'b1;
      drain();
      repeat (6) @(posedge clk);
      #1;
      check("full_op_count", 32'(op_count), 32'd5);
      check("full_drained_ready", 32'(cmd_ready), 32'd1);

      // Reset while holding a response with two commands queued
      rsp_ready = 1'b0;
      push(4'd1, 4'd1, 2'b00, 4'd2);
      push(4'd2, 4'd2, 2'b00, 4'd4);
      push(4'd3, 4'd3, 2'b00, 4'd6);
      check("pre_rst_hold", 32'(rsp_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_op_count", 32'(op_count), 32'd0);
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("post_mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
      check("post_mid_rst_op_count", 32'(op_count), 32'd0);

      // op_count wrap after 256 handshakes
      for (int i = 0; i < 255; i++) begin
         push(4'(i), 4'd1, 2'b00, 4'(i + 1));
      end
      drain();
      check("wrap_op_count_255", 32'(op_count), 32'd255);
      push(4'd14, 4'd3, 2'b00, 4'd1);
      drain();
      check("wrap_op_count_0", 32'(op_count), 32'd0);

      repeat (4) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
